// File: rtl/axi4l_periph_pkg.sv
// Shared types and constants for the AXI4-lite memory/peripheral slave:
// response codes, channel FSM states, address-region decode and default map.
package axi4l_periph_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int          DEF_MEM_BYTES    = 131072;
  localparam int          DEF_NUM_REGS     = 32;
  localparam logic [31:0] DEF_PERIPH_BASE  = 32'h2500_0000;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR    = 32'h2100_0000;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rd_state_e;

  typedef enum logic [2:0] {
    REG_RAM, REG_CONSOLE, REG_PASS, REG_PERIPH, REG_ERR
  } region_e;

endpackage

// File: rtl/byte_en_ram.sv
// Word-organised RAM with a byte-enabled write port and a registered read
// port; a same-cycle read of the word being written returns the old contents.
module byte_en_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4l_mem_periph_gen.sv
// AXI4-lite slave with byte-enabled RAM, console byte port, sticky pass flag
// and an N-register peripheral window; read and write channels run independently.
module axi4l_mem_periph_gen
  import axi4l_periph_pkg::*;
#(
  parameter int          MEM_BYTES    = DEF_MEM_BYTES,
  parameter logic [31:0] PERIPH_BASE  = DEF_PERIPH_BASE,
  parameter int          NUM_REGS     = DEF_NUM_REGS,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter int          IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_awvalid,
  output logic             s_awready,
  input  logic [31:0]      s_awaddr,
  input  logic             s_wvalid,
  output logic             s_wready,
  input  logic [31:0]      s_wdata,
  input  logic [3:0]       s_wstrb,
  output logic             s_bvalid,
  input  logic             s_bready,
  output logic [1:0]       s_bresp,
  input  logic             s_arvalid,
  output logic             s_arready,
  input  logic [31:0]      s_araddr,
  output logic             s_rvalid,
  input  logic             s_rready,
  output logic [31:0]      s_rdata,
  output logic [1:0]       s_rresp,
  output logic             reg_wr_en,
  output logic [IDX_W-1:0] reg_wr_idx,
  output logic [31:0]      reg_wr_data,
  output logic [3:0]       reg_wr_strb,
  output logic [IDX_W-1:0] reg_rd_idx,
  input  logic [31:0]      reg_rd_data,
  output logic             console_valid,
  output logic [7:0]       console_data,
  output logic             tests_passed
);

  localparam int DEPTH_WORDS = MEM_BYTES / 4;
  localparam int RAM_AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  function automatic region_e decode(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr & 32'hFFFF_FFFC};
    if (a < 33'(MEM_BYTES)) return REG_RAM;
    if (a[31:0] == (CONSOLE_ADDR & 32'hFFFF_FFFC)) return REG_CONSOLE;
    if (a[31:0] == (PASS_ADDR & 32'hFFFF_FFFC)) return REG_PASS;
    if (a >= {1'b0, PERIPH_BASE} && a < ({1'b0, PERIPH_BASE} + 33'(4 * NUM_REGS)))
      return REG_PERIPH;
    return REG_ERR;
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [31:0] addr);
    return IDX_W'((addr - PERIPH_BASE) >> 2);
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Readies stay low while reset is asserted and for the release cycle.
  logic        live_q;
  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        passed_q, passed_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] araddr_q, araddr_d, rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rsrc_ram_q, rsrc_ram_d;

  region_e     wr_region, rd_region;
  logic        commit;
  logic        ram_re;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign wr_region = decode(awaddr_q);
  assign rd_region = decode(araddr_q);
  assign commit    = (wr_state_q == W_COMMIT);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_lat_d   = aw_lat_q;
    w_lat_d    = w_lat_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    passed_d   = passed_q;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        s_awready = live_q && !aw_lat_q;
        s_wready  = live_q && !w_lat_q;
        if (s_awvalid && s_awready) begin
          aw_lat_d = 1'b1;
          awaddr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
          w_lat_d = 1'b1;
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
        end
        if (aw_lat_d && w_lat_d) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        bresp_d = (wr_region == REG_ERR) ? RESP_SLVERR : RESP_OKAY;
        if (wr_region == REG_PASS && wdata_q == 32'd1) passed_d = 1'b1;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_bready) begin
          wr_state_d = W_IDLE;
          aw_lat_d   = 1'b0;
          w_lat_d    = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rsrc_ram_d = rsrc_ram_q;
    s_arready  = 1'b0;
    ram_re     = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        s_arready = live_q;
        if (s_arvalid && live_q) begin
          araddr_d   = s_araddr;
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re     = (rd_region == REG_RAM);
        rsrc_ram_d = ram_re;
        rdata_d    = (rd_region == REG_PERIPH) ? reg_rd_data : 32'h0;
        rresp_d    = (rd_region == REG_RAM || rd_region == REG_PERIPH) ? RESP_OKAY : RESP_SLVERR;
        rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_q     <= 1'b0;
      wr_state_q <= W_IDLE;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      passed_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rsrc_ram_q <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      aw_lat_q   <= aw_lat_d;
      w_lat_q    <= w_lat_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      passed_q   <= passed_d;
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rsrc_ram_q <= rsrc_ram_d;
    end
  end

  assign ram_we = (commit && wr_region == REG_RAM) ? wstrb_q : 4'b0000;

  byte_en_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (RAM_AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(RAM_AW'(awaddr_q >> 2)),
    .wdata_i(wdata_q),
    .re_i   (ram_re),
    .raddr_i(RAM_AW'(araddr_q >> 2)),
    .rdata_o(ram_rdata)
  );

  assign s_bvalid      = (wr_state_q == W_RESP);
  assign s_bresp       = bresp_q;
  assign s_rvalid      = (rd_state_q == R_RESP);
  assign s_rdata       = !s_rvalid ? 32'h0 : (rsrc_ram_q ? ram_rdata : rdata_q);
  assign s_rresp       = rresp_q;
  assign reg_wr_en     = commit && (wr_region == REG_PERIPH);
  assign reg_wr_idx    = reg_idx(awaddr_q);
  assign reg_wr_data   = wdata_q & strb_mask(wstrb_q);
  assign reg_wr_strb   = wstrb_q;
  assign reg_rd_idx    = reg_idx(araddr_q);
  assign console_valid = commit && (wr_region == REG_CONSOLE);
  assign console_data  = console_valid ? wdata_q[7:0] : 8'h00;
  assign tests_passed  = passed_q;

endmodule

// File: tb/tb_axi4l_mem_periph_gen.sv
// Self-checking bench: table of single transactions, hand-built timing
// sequences, and random RAM/register traffic against a word-array model.
module tb_axi4l_mem_periph_gen;
  localparam int          MB   = 4096;
  localparam int          NR   = 32;
  localparam int          IW   = 5;
  localparam logic [31:0] PB   = 32'h2500_0000;
  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] PASS = 32'h2100_0000;

  logic clk, resetn;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic reg_wr_en, console_valid, tests_passed;
  logic [IW-1:0] reg_wr_idx, reg_rd_idx;
  logic [31:0] reg_wr_data, reg_rd_data;
  logic [3:0]  reg_wr_strb;
  logic [7:0]  console_data;

  int total = 0, bad = 0;
  int wr_pulses = 0, con_pulses = 0;
  logic [IW-1:0] seen_idx;
  logic [31:0]   seen_wdata;
  logic [3:0]    seen_strb;
  logic [7:0]    seen_con;

  function automatic logic [31:0] periph_val(input logic [IW-1:0] idx);
    if (idx == 1) return 32'h1;
    return 32'hC0DE_0000 | {27'h0, idx};
  endfunction

  assign reg_rd_data = periph_val(reg_rd_idx);

  axi4l_mem_periph_gen #(.MEM_BYTES(MB), .NUM_REGS(NR)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
    .console_valid(console_valid), .console_data(console_data),
    .tests_passed(tests_passed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_pulses  <= wr_pulses + 1;
      seen_idx   <= reg_wr_idx;
      seen_wdata <= reg_wr_data;
      seen_strb  <= reg_wr_strb;
    end
    if (console_valid) begin
      con_pulses <= con_pulses + 1;
      seen_con   <= console_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT handshake", nm);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit got = 0;
    resp = 2'bxx;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (s_bvalid) begin got = 1; resp = s_bresp; end
      @(posedge clk); #1;
    end
    if (!got) tmo("bvalid_wait");
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    data = 'x;
    resp = 2'bxx;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (s_rvalid) begin got = 1; data = s_rdata; resp = s_rresp; end
      @(posedge clk); #1;
    end
    if (!got) tmo("rvalid_wait");
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, output logic [1:0] resp);
    bit awd = 0, wd = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int n = 0; n < 40 && !(awd && wd); n++) begin
      @(negedge clk);
      if (s_awvalid && s_awready) awd = 1;
      if (s_wvalid && s_wready) wd = 1;
      @(posedge clk); #1;
      if (awd) s_awvalid = 1'b0;
      if (wd) s_wvalid = 1'b0;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!(awd && wd)) begin tmo("aw_w_wait"); resp = 2'bxx; end
    else wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit ard = 0;
    s_araddr = a; s_arvalid = 1'b1;
    for (int n = 0; n < 40 && !ard; n++) begin
      @(negedge clk);
      if (s_arready) ard = 1;
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    if (!ard) begin tmo("ar_wait"); data = 'x; resp = 2'bxx; end
    else wait_r(data, resp);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       nm;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] ref_mem [16];

  initial begin
    logic [1:0]  r;
    logic [31:0] rd, d, oldv;
    logic [3:0]  st;
    int p0, c0, viol, sel, k, idx;

    vt.push_back('{1'b1, 32'h0000_0100, 32'h0000_0000, 4'hF, 2'b00, 32'h0, "w100_clear"});
    vt.push_back('{1'b1, 32'h0000_0100, 32'hA5A5_1234, 4'h5, 2'b00, 32'h0, "w100_strb5"});
    vt.push_back('{1'b0, 32'h0000_0100, 32'h0, 4'h0, 2'b00, 32'h00A5_0034, "r100"});
    vt.push_back('{1'b0, 32'h0000_0103, 32'h0, 4'h0, 2'b00, 32'h00A5_0034, "r103_lowbits"});
    vt.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 2'b00, 32'h0, "w0"});
    vt.push_back('{1'b1, MB,            32'h2222_2222, 4'hF, 2'b10, 32'h0, "w_membytes_err"});
    vt.push_back('{1'b0, 32'h0000_0000, 32'h0, 4'h0, 2'b00, 32'h1111_1111, "r0_nowrap"});
    vt.push_back('{1'b0, MB,            32'h0, 4'h0, 2'b10, 32'h0, "r_membytes_err"});
    vt.push_back('{1'b1, MB - 4,        32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0, "w_lastword"});
    vt.push_back('{1'b0, MB - 4,        32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF, "r_lastword"});
    vt.push_back('{1'b0, PB + 4,        32'h0, 4'h0, 2'b00, 32'h1, "r_reg1"});
    vt.push_back('{1'b0, PB + 4*(NR-1), 32'h0, 4'h0, 2'b00, periph_val(IW'(NR-1)), "r_reg_last"});
    vt.push_back('{1'b0, PB + 4*NR,     32'h0, 4'h0, 2'b10, 32'h0, "r_reg_past_end"});
    vt.push_back('{1'b0, PB - 4,        32'h0, 4'h0, 2'b10, 32'h0, "r_below_window"});
    vt.push_back('{1'b1, PB + 4*NR,     32'h1234_5678, 4'hF, 2'b10, 32'h0, "w_reg_past_end"});
    vt.push_back('{1'b1, 32'hDEAD_0000, 32'h0, 4'hF, 2'b10, 32'h0, "w_unmapped"});
    vt.push_back('{1'b0, 32'h3000_0000, 32'h0, 4'h0, 2'b10, 32'h0, "r_unmapped"});
    vt.push_back('{1'b0, CON,           32'h0, 4'h0, 2'b10, 32'h0, "r_console_wo"});
    vt.push_back('{1'b0, PASS,          32'h0, 4'h0, 2'b10, 32'h0, "r_pass_wo"});

    resetn = 1'b0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {21'h0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
        tests_passed, reg_wr_en, console_valid, s_bresp, s_rresp}, 32'h0);
    chk("reset_data", s_rdata | reg_wr_data | {27'h0, reg_wr_idx} | {27'h0, reg_rd_idx}
        | {28'h0, reg_wr_strb} | {24'h0, console_data}, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    p0 = wr_pulses; c0 = con_pulses;
    foreach (vt[i]) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
        chk({vt[i].nm, "_bresp"}, {30'h0, r}, {30'h0, vt[i].resp});
      end else begin
        axi_read(vt[i].addr, rd, r);
        chk({vt[i].nm, "_rresp"}, {30'h0, r}, {30'h0, vt[i].resp});
        chk({vt[i].nm, "_rdata"}, rd, vt[i].rdata);
      end
    end
    chk("table_no_side_pulses", wr_pulses - p0 + con_pulses - c0, 0);

    // Read latency: handshake cycle, fetch cycle, then rvalid.
    s_araddr = 32'h100; s_arvalid = 1'b1;
    @(negedge clk); chk("lat_arready", {31'h0, s_arready}, 1);
    @(posedge clk); #1 s_arvalid = 1'b0;
    @(negedge clk); chk("lat_fetch_rvalid_low", {31'h0, s_rvalid}, 0);
    @(posedge clk);
    @(negedge clk); chk("lat_rvalid_high", {31'h0, s_rvalid}, 1);
    chk("lat_rdata", s_rdata, 32'h00A5_0034);
    @(posedge clk); #1;

    // W three cycles ahead of AW, register window write.
    p0 = wr_pulses;
    s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge clk); #1 s_wvalid = 1'b0;
    repeat (2) @(posedge clk); #1;
    s_awaddr = PB + 8; s_awvalid = 1'b1;
    @(negedge clk); chk("wfirst_readies", {30'h0, s_awready, s_wready}, 32'h2);
    @(posedge clk); #1 s_awvalid = 1'b0;
    wait_b(r);
    chk("wfirst_bresp", {30'h0, r}, 0);
    chk("wfirst_pulse_count", wr_pulses - p0, 1);
    chk("wfirst_idx", {27'h0, seen_idx}, 2);
    chk("wfirst_data", seen_wdata, 32'hCAFE_F00D);
    chk("wfirst_strb", {28'h0, seen_strb}, 32'hF);

    // Console and sticky pass flag.
    c0 = con_pulses;
    axi_write(CON, 32'h0000_0041, 4'hF, r);
    chk("con_bresp", {30'h0, r}, 0);
    chk("con_pulse_count", con_pulses - c0, 1);
    chk("con_data", {24'h0, seen_con}, 32'h41);
    axi_write(PASS, 32'h2, 4'hF, r);
    chk("pass2_bresp", {30'h0, r}, 0);
    chk("pass_after_2", {31'h0, tests_passed}, 0);
    axi_write(PASS, 32'h1, 4'hF, r);
    chk("pass_after_1", {31'h0, tests_passed}, 1);
    axi_write(PASS, 32'h0, 4'hF, r);
    repeat (3) @(posedge clk); #1;
    chk("pass_sticky", {31'h0, tests_passed}, 1);

    // Random traffic over 16 known RAM words and the register window.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      axi_write(32'h400 + 4*i, ref_mem[i], 4'hF, r);
      chk("rnd_init_bresp", {30'h0, r}, 0);
    end
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 99);
      k   = $urandom_range(0, 15);
      if (sel < 45) begin
        d = $urandom; st = 4'($urandom_range(0, 15));
        axi_write(32'h400 + 4*k, d, st, r);
        chk("rnd_w_bresp", {30'h0, r}, 0);
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[k][8*b +: 8] = d[8*b +: 8];
      end else if (sel < 85) begin
        axi_read(32'h400 + 4*k + $urandom_range(0, 3), rd, r);
        chk("rnd_r_rresp", {30'h0, r}, 0);
        chk("rnd_r_rdata", rd, ref_mem[k]);
      end else begin
        idx = $urandom_range(0, NR - 1);
        axi_read(PB + 4*idx, rd, r);
        chk("rnd_reg_rresp", {30'h0, r}, 0);
        chk("rnd_reg_rdata", rd, periph_val(IW'(idx)));
      end
    end

    // Write commit and read fetch of the same word in the same cycle.
    oldv = ref_mem[0]; d = ~oldv;
    s_awaddr = 32'h400; s_wdata = d; s_wstrb = 4'hF; s_araddr = 32'h400;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge clk); chk("rbw_readies", {29'h0, s_awready, s_wready, s_arready}, 32'h7);
    @(posedge clk); #1 begin s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; end
    @(posedge clk);
    @(negedge clk);
    chk("rbw_valids", {30'h0, s_bvalid, s_rvalid}, 32'h3);
    chk("rbw_old_data", s_rdata, oldv);
    @(posedge clk); #1;
    ref_mem[0] = d;
    axi_read(32'h400, rd, r);
    chk("rbw_new_data", rd, d);

    // bready held low with a second AW waiting.
    s_bready = 1'b0;
    d = $urandom;
    s_awaddr = 32'h408; s_wdata = d; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1 begin s_awvalid = 0; s_wvalid = 0; end
    ref_mem[2] = d;
    s_awaddr = 32'h40C; s_awvalid = 1'b1;
    @(posedge clk);
    viol = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (!s_bvalid || s_awready) viol++;
      @(posedge clk);
    end
    chk("bhold_violations", viol, 0);
    #1 s_bready = 1'b1;
    @(negedge clk); chk("bhold_last", {30'h0, s_bvalid, s_awready}, 32'h2);
    @(posedge clk);
    @(negedge clk); chk("bhold_aw_accept", {31'h0, s_awready}, 1);
    @(posedge clk); #1 s_awvalid = 1'b0;
    d = $urandom; s_wdata = d; s_wvalid = 1'b1;
    @(negedge clk); chk("bhold_wready", {31'h0, s_wready}, 1);
    @(posedge clk); #1 s_wvalid = 1'b0;
    wait_b(r);
    chk("bhold_2nd_bresp", {30'h0, r}, 0);
    ref_mem[3] = d;
    axi_read(32'h408, rd, r); chk("bhold_word1", rd, ref_mem[2]);
    axi_read(32'h40C, rd, r); chk("bhold_word2", rd, ref_mem[3]);

    // Reset while a read is in its fetch cycle.
    s_araddr = 32'h100; s_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 s_arvalid = 1'b0;
    #2 resetn = 1'b0;
    #1 chk("rst_async_outs", {29'h0, s_rvalid, s_arready, tests_passed}, 0);
    @(negedge clk); chk("rst_held_outs", {29'h0, s_rvalid, s_arready, tests_passed}, 0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h100, rd, r);
    chk("rst_after_rresp", {30'h0, r}, 0);
    chk("rst_after_rdata", rd, 32'h00A5_0034);
    chk("rst_pass_cleared", {31'h0, tests_passed}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
